// File: rtl/flac_pkg.sv
// Shared definitions for the Rice residual decoder: default parameters,
// FSM state encoding and the escape-code helper.
package flac_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int PARAM_W_DEF = 5;
  localparam int COUNT_W_DEF = 16;
  localparam int MAX_MSB_DEF = 4095;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNARY  = 3'd1,
    BINARY = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } state_e;

  // All-ones Rice parameter selects the raw (escape) coding
  function automatic int esc_code(input int param_w);
    return (1 << param_w) - 1;
  endfunction

endpackage

// File: rtl/rice_stream_decoder_if.sv
// Bundle of the decoder's partition-control, bit-stream and residual handshake signals.
interface rice_stream_decoder_if import flac_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PARAM_W = PARAM_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
);
  logic               iStart;
  logic [PARAM_W-1:0] iRiceParam;
  logic [4:0]         iRawBits;
  logic [COUNT_W-1:0] iCount;
  logic               iBit;
  logic               iBitValid;
  logic               oBitReady;
  logic [DATA_W-1:0]  oData;
  logic               oValid;
  logic               iReady;
  logic               oBusy;
  logic               oDone;
  logic               oError;

  modport master (
    output iStart, iRiceParam, iRawBits, iCount, iBit, iBitValid, iReady,
    input  oBitReady, oData, oValid, oBusy, oDone, oError
  );

  modport slave (
    input  iStart, iRiceParam, iRawBits, iCount, iBit, iBitValid, iReady,
    output oBitReady, oData, oValid, oBusy, oDone, oError
  );
endinterface

// File: rtl/rice_unfold.sv
// Turns a decoded quotient/remainder (Rice) or raw field (escape) into the
// signed residual: zigzag unfolding or sign extension.
module rice_unfold #(
  parameter int DATA_W  = 32,
  parameter int Q_W     = 12,
  parameter int PARAM_W = 5
) (
  input  logic [Q_W-1:0]     i_q,
  input  logic [DATA_W-1:0]  i_rem,
  input  logic [PARAM_W-1:0] i_k,
  input  logic [4:0]         i_n,
  input  logic               i_escape,
  output logic [DATA_W-1:0]  o_data
);
  localparam int SH_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] w_uval;
  logic [DATA_W-1:0] w_half;
  logic [DATA_W-1:0] w_ext;
  logic [SH_W-1:0]   w_sh;

  // -(x)-1 equals ~x, so odd codes map to the bitwise inverse of the half value
  always_comb begin
    w_uval = (DATA_W'(i_q) << i_k) | i_rem;
    w_half = w_uval >> 1;
    w_sh   = '0;
    w_ext  = '0;
    if (i_n == 5'd0) begin
      w_ext = '0;
    end else if (32'(i_n) >= DATA_W) begin
      w_ext = i_rem;
    end else begin
      w_sh  = SH_W'(DATA_W - 32'(i_n));
      w_ext = DATA_W'($signed(i_rem << w_sh) >>> w_sh);
    end
    if (i_escape) begin
      o_data = w_ext;
    end else if (w_uval[0]) begin
      o_data = ~w_half;
    end else begin
      o_data = w_half;
    end
  end
endmodule

// File: rtl/rice_stream_decoder.sv
// Serial Rice/escape residual decoder: consumes an MSB-first bit stream and
// emits one signed residual per handshake for a partition of iCount residuals.
module rice_stream_decoder import flac_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PARAM_W = PARAM_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int MAX_MSB = MAX_MSB_DEF
) (
  input  logic               iClock,
  input  logic               iReset_n,
  input  logic               iStart,
  input  logic [PARAM_W-1:0] iRiceParam,
  input  logic [4:0]         iRawBits,
  input  logic [COUNT_W-1:0] iCount,
  input  logic               iBit,
  input  logic               iBitValid,
  output logic               oBitReady,
  output logic [DATA_W-1:0]  oData,
  output logic               oValid,
  input  logic               iReady,
  output logic               oBusy,
  output logic               oDone,
  output logic               oError
);
  localparam int Q_W = (MAX_MSB < 1) ? 1 : $clog2(MAX_MSB + 1);
  localparam int B_W = (PARAM_W > 5) ? PARAM_W : 5;
  localparam logic [PARAM_W-1:0] ESC = PARAM_W'(esc_code(PARAM_W));

  state_e             r_state, w_state_nxt;
  logic [PARAM_W-1:0] r_k, w_k_nxt;
  logic [4:0]         r_n, w_n_nxt;
  logic               r_esc, w_esc_nxt;
  logic [COUNT_W-1:0] r_count, w_count_nxt;
  logic [Q_W-1:0]     r_q, w_q_nxt;
  logic [DATA_W-1:0]  r_rem, w_rem_nxt;
  logic [B_W-1:0]     r_bits, w_bits_nxt;
  logic               r_error, w_err_nxt;
  logic [DATA_W-1:0]  r_data, w_unfold;
  logic               r_valid, r_bit_ready, r_busy, r_done;
  logic               w_take, w_load;

  function automatic state_e first_state(input logic esc, input logic [4:0] n);
    if (esc) begin
      return (n == 5'd0) ? EMIT : BINARY;
    end else begin
      return UNARY;
    end
  endfunction

  // Next-state, counters and shift register; unfold sees the post-edge values
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_n_nxt     = r_n;
    w_esc_nxt   = r_esc;
    w_count_nxt = r_count;
    w_q_nxt     = r_q;
    w_rem_nxt   = r_rem;
    w_bits_nxt  = r_bits;
    w_err_nxt   = r_error;
    w_take      = iBitValid && r_bit_ready;
    case (r_state)
      IDLE: begin
        if (iStart) begin
          w_k_nxt     = iRiceParam;
          w_n_nxt     = iRawBits;
          w_esc_nxt   = (iRiceParam == ESC);
          w_count_nxt = iCount;
          w_q_nxt     = '0;
          w_rem_nxt   = '0;
          w_bits_nxt  = B_W'(iRawBits);
          w_err_nxt   = 1'b0;
          if (iCount == '0) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = first_state(iRiceParam == ESC, iRawBits);
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      UNARY: begin
        if (!w_take) begin
          w_state_nxt = UNARY;
        end else if (iBit) begin
          w_bits_nxt  = B_W'(r_k);
          w_state_nxt = (r_k == '0) ? EMIT : BINARY;
        end else if (r_q == Q_W'(MAX_MSB)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_q_nxt = r_q + Q_W'(1);
        end
      end
      BINARY: begin
        if (w_take) begin
          w_rem_nxt  = {r_rem[DATA_W-2:0], iBit};
          w_bits_nxt = r_bits - B_W'(1);
          if (r_bits == B_W'(1)) begin
            w_state_nxt = EMIT;
          end else begin
            w_state_nxt = BINARY;
          end
        end else begin
          w_state_nxt = BINARY;
        end
      end
      EMIT: begin
        if (iReady) begin
          w_count_nxt = r_count - COUNT_W'(1);
          w_q_nxt     = '0;
          w_rem_nxt   = '0;
          w_bits_nxt  = B_W'(r_n);
          if (r_count == COUNT_W'(1)) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = first_state(r_esc, r_n);
          end
        end else begin
          w_state_nxt = EMIT;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_load = (w_state_nxt == EMIT) && ((r_state != EMIT) || iReady);
  end

  rice_unfold #(.DATA_W(DATA_W), .Q_W(Q_W), .PARAM_W(PARAM_W)) u_unfold (
    .i_q      (w_q_nxt),
    .i_rem    (w_rem_nxt),
    .i_k      (w_k_nxt),
    .i_n      (w_n_nxt),
    .i_escape (w_esc_nxt),
    .o_data   (w_unfold)
  );

  // State, datapath and registered outputs
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_n         <= '0;
      r_esc       <= 1'b0;
      r_count     <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_bits      <= '0;
      r_error     <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_bit_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_n         <= w_n_nxt;
      r_esc       <= w_esc_nxt;
      r_count     <= w_count_nxt;
      r_q         <= w_q_nxt;
      r_rem       <= w_rem_nxt;
      r_bits      <= w_bits_nxt;
      r_error     <= w_err_nxt;
      r_data      <= w_load ? w_unfold : r_data;
      r_valid     <= (w_state_nxt == EMIT);
      r_bit_ready <= (w_state_nxt == UNARY) || (w_state_nxt == BINARY);
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= (w_state_nxt == DONE);
    end
  end

  assign oData     = r_data;
  assign oValid    = r_valid;
  assign oBitReady = r_bit_ready;
  assign oBusy     = r_busy;
  assign oDone     = r_done;
  assign oError    = r_error;
endmodule

// File: tb/tb_rice_stream_decoder.sv
// Randomized bench: residual values are Rice/escape-encoded into a bit queue
// by the bench, streamed with random gaps/back-pressure, and compared on output.
module tb_rice_stream_decoder;
  localparam int DW = 32;
  localparam int PW = 5;
  localparam int CW = 16;
  localparam int MM = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rice_stream_decoder_if #(.DATA_W(DW), .PARAM_W(PW), .COUNT_W(CW)) bus ();

  rice_stream_decoder #(.DATA_W(DW), .PARAM_W(PW), .COUNT_W(CW), .MAX_MSB(MM)) dut (
    .iClock(clk), .iReset_n(rst_n), .iStart(bus.iStart), .iRiceParam(bus.iRiceParam),
    .iRawBits(bus.iRawBits), .iCount(bus.iCount), .iBit(bus.iBit), .iBitValid(bus.iBitValid),
    .oBitReady(bus.oBitReady), .oData(bus.oData), .oValid(bus.oValid), .iReady(bus.iReady),
    .oBusy(bus.oBusy), .oDone(bus.oDone), .oError(bus.oError)
  );

  int checks = 0;
  int errors = 0;
  bit              q_bits[$];
  int              q_len[$];
  logic [DW-1:0]   q_exp[$];

  task automatic clear_model();
    q_bits.delete();
    q_len.delete();
    q_exp.delete();
  endtask

  // Encode signed v: zigzag to unsigned, q zeros, a one, then k low bits MSB-first
  task automatic add_rice(input int k, input longint v);
    longint u;
    longint q;
    u = (v >= 0) ? 2 * v : -2 * v - 1;
    q = u >> k;
    for (longint i = 0; i < q; i++) q_bits.push_back(1'b0);
    q_bits.push_back(1'b1);
    for (int i = k - 1; i >= 0; i--) q_bits.push_back(u[i]);
    q_len.push_back(int'(q) + 1 + k);
    q_exp.push_back(DW'(v));
  endtask

  task automatic add_esc(input int n, input longint raw);
    longint s;
    for (int i = n - 1; i >= 0; i--) q_bits.push_back(raw[i]);
    s = raw;
    if (n > 0 && raw[n-1]) s = raw - (longint'(1) << n);
    q_len.push_back(n);
    q_exp.push_back(DW'(s));
  endtask

  task automatic fill_random(output int k, output int n, output int count);
    longint raw;
    count = $urandom_range(1, 5);
    n = 0;
    if ($urandom_range(0, 2) == 0) begin
      k = 31;
      n = $urandom_range(0, 31);
      for (int i = 0; i < count; i++) begin
        raw = longint'($urandom) & ((longint'(1) << n) - 1);
        add_esc(n, raw);
      end
    end else begin
      k = $urandom_range(0, 10);
      for (int i = 0; i < count; i++)
        add_rice(k, longint'($urandom_range(0, (8 << k) - 1)) - longint'(4 << k));
    end
  endtask

  task automatic run_partition(input int k, input int n, input int count, input bit stall);
    bit take, rdy, consumed, done, stalled;
    int budget;
    logic [DW-1:0] held;
    bus.iRiceParam = PW'(k);
    bus.iRawBits = 5'(n);
    bus.iCount = CW'(count);
    bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    checks++;
    if (bus.oBusy !== 1'b1 || bus.oError !== 1'b0) begin
      errors++;
      $display("FAIL start_flags busy=%b err=%b required busy=1 err=0", bus.oBusy, bus.oError);
    end
    done = 0; stalled = 0; budget = 0;
    while (!done && budget < 3000) begin
      budget++;
      if (bus.oDone === 1'b1) begin
        done = 1;
        checks++;
        if (q_exp.size() != 0 || q_bits.size() != 0) begin
          errors++;
          $display("FAIL done_early pending_data=%0d pending_bits=%0d required 0 and 0", q_exp.size(), q_bits.size());
        end
      end else begin
        if (stall && !stalled && bus.oValid === 1'b1) begin
          stalled = 1;
          held = bus.oData;
          for (int i = 0; i < 5; i++) begin
            bus.iReady = 1'b0; bus.iBitValid = 1'b1; bus.iBit = 1'b1;
            bus.iStart = (i == 2); bus.iCount = CW'(9); bus.iRiceParam = '0;
            @(posedge clk); #1;
            checks++;
            if (bus.oData !== held || bus.oValid !== 1'b1 || bus.oBitReady !== 1'b0 || bus.oBusy !== 1'b1) begin
              errors++;
              $display("FAIL stall_hold data=%h valid=%b rdy=%b busy=%b required data=%h valid=1 rdy=0 busy=1",
                       bus.oData, bus.oValid, bus.oBitReady, bus.oBusy, held);
            end
          end
          bus.iStart = 1'b0;
        end
        take = (q_bits.size() > 0) && ($urandom_range(0, 3) != 0);
        bus.iBitValid = take;
        bus.iBit = take ? q_bits[0] : 1'($urandom_range(0, 1));
        rdy = ($urandom_range(0, 2) != 0);
        bus.iReady = rdy;
        consumed = take && (bus.oBitReady === 1'b1);
        if (bus.oValid === 1'b1 && rdy) begin
          checks++;
          if (q_exp.size() == 0) begin
            errors++;
            $display("FAIL extra_data got=%h required no residual", bus.oData);
          end else begin
            if (bus.oData !== q_exp[0]) begin
              errors++;
              $display("FAIL residual k=%0d n=%0d got=%h required %h", k, n, bus.oData, q_exp[0]);
            end
            void'(q_exp.pop_front());
            void'(q_len.pop_front());
          end
        end
        @(posedge clk); #1;
        if (consumed && q_bits.size() > 0 && q_len.size() > 0) begin
          void'(q_bits.pop_front());
          q_len[0] = q_len[0] - 1;
          if (q_len[0] == 0) begin
            checks++;
            if (bus.oValid !== 1'b1) begin
              errors++;
              $display("FAIL latency valid=%b required 1 the cycle after the last bit", bus.oValid);
            end
          end
        end
      end
    end
    bus.iBitValid = 1'b0;
    bus.iReady = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout no oDone within budget, pending_data=%0d required done", q_exp.size());
    end
    @(posedge clk); #1;
    checks++;
    if (bus.oDone !== 1'b0 || bus.oBusy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b busy=%b required 0 0", bus.oDone, bus.oBusy);
    end
    clear_model();
  endtask

  task automatic test_reset();
    bus.iStart = 0; bus.iRiceParam = '0; bus.iRawBits = '0; bus.iCount = '0;
    bus.iBit = 0; bus.iBitValid = 0; bus.iReady = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.oValid, bus.oBitReady, bus.oBusy, bus.oDone, bus.oError} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags got=%b required 00000", {bus.oValid, bus.oBitReady, bus.oBusy, bus.oDone, bus.oError});
    end
    checks++;
    if (bus.oData !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h required 0", bus.oData);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    add_rice(2, 5);   run_partition(2, 0, 1, 0);
    add_rice(2, -2);  run_partition(2, 0, 1, 0);
    add_rice(0, -2);  run_partition(0, 0, 1, 0);
    add_esc(4, 14);   run_partition(31, 4, 1, 0);
    repeat (3) add_esc(0, 0);
    run_partition(31, 0, 3, 0);
    run_partition(3, 0, 0, 0);
    add_esc(31, 64'h4000_0001); add_esc(31, 64'h0000_00ff);
    run_partition(31, 31, 2, 0);
  endtask

  task automatic test_stall();
    add_rice(3, longint'($urandom_range(0, 63)) - 32);
    add_rice(3, longint'($urandom_range(0, 63)) - 32);
    run_partition(3, 0, 2, 1);
  endtask

  task automatic test_random();
    int k, n, count;
    for (int t = 0; t < 14; t++) begin
      fill_random(k, n, count);
      run_partition(k, n, count, 0);
    end
  endtask

  task automatic test_error();
    int zeros = 0;
    bit seen_done = 0;
    bit consumed;
    bus.iRiceParam = '0; bus.iRawBits = '0; bus.iCount = CW'(2); bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    for (int i = 0; i < 60 && zeros < MM + 1; i++) begin
      bus.iBitValid = 1'($urandom_range(0, 1));
      bus.iBit = 1'b0;
      consumed = bus.iBitValid && (bus.oBitReady === 1'b1);
      @(posedge clk); #1;
      if (bus.oDone === 1'b1) seen_done = 1;
      if (consumed) zeros++;
      if (consumed && zeros == MM) begin
        checks++;
        if (bus.oError !== 1'b0 || bus.oBusy !== 1'b1) begin
          errors++;
          $display("FAIL error_early err=%b busy=%b required 0 1 at quotient limit", bus.oError, bus.oBusy);
        end
      end
    end
    bus.iBitValid = 1'b0;
    checks++;
    if (zeros != MM + 1 || bus.oError !== 1'b1 || bus.oBusy !== 1'b0 || bus.oBitReady !== 1'b0 || bus.oValid !== 1'b0) begin
      errors++;
      $display("FAIL overflow zeros=%0d err=%b busy=%b rdy=%b valid=%b required %0d 1 0 0 0",
               zeros, bus.oError, bus.oBusy, bus.oBitReady, bus.oValid, MM + 1);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.oDone === 1'b1) seen_done = 1;
    end
    checks++;
    if (seen_done || bus.oError !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky done_seen=%0d err=%b required 0 1", seen_done, bus.oError);
    end
    add_rice(1, -3);
    run_partition(1, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    int k, n, count;
    bus.iRiceParam = PW'(4); bus.iRawBits = '0; bus.iCount = CW'(2); bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    bus.iBitValid = 1'b1;
    bus.iBit = 1'b1; @(posedge clk); #1;
    bus.iBit = 1'b1; @(posedge clk); #1;
    bus.iBit = 1'b0; @(posedge clk); #1;
    bus.iBitValid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.oValid, bus.oBitReady, bus.oBusy, bus.oDone, bus.oError} !== 5'b00000 || bus.oData !== '0) begin
      errors++;
      $display("FAIL reset_mid flags=%b data=%h required 00000 and 0",
               {bus.oValid, bus.oBitReady, bus.oBusy, bus.oDone, bus.oError}, bus.oData);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_model();
    fill_random(k, n, count);
    run_partition(k, n, count, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
